// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, FSM state type and byte-lane merge helper for regfile_mp
package regfile_pkg;

    localparam int RF_DEF_DATA_W   = 32;
    localparam int RF_DEF_NUM_REGS = 32;

    typedef enum logic {RF_INIT, RF_RUN} rf_state_e;

    // One lane of a byte-enabled write; shared by the storage write and the read bypass.
    function automatic logic [7:0] rf_byte_merge(input logic [7:0] old_b,
                                                 input logic [7:0] new_b,
                                                 input logic       be);
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-writeback bits, set wins over clear
module regfile_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_set_en,
    input  logic [AW-1:0] i_set_addr,
    input  logic          i_clr_en,
    input  logic [AW-1:0] i_clr_addr,
    input  logic [AW-1:0] i_rd1_addr,
    input  logic [AW-1:0] i_rd2_addr,
    output logic          o_rd1_busy,
    output logic          o_rd2_busy
);

    localparam logic [AW:0] NREGS = (AW+1)'(NUM_REGS);

    logic [NUM_REGS-1:0] r_busy;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Clear first, then set, so a same-cycle reissue leaves the bit pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (i_clr_en && addr_ok(i_clr_addr)) r_busy[i_clr_addr] <= 1'b0;
            if (i_set_en && addr_ok(i_set_addr)) r_busy[i_set_addr] <= 1'b1;
        end
    end

    assign o_rd1_busy = addr_ok(i_rd1_addr) ? r_busy[i_rd1_addr] : 1'b0;
    assign o_rd2_busy = addr_ok(i_rd2_addr) ? r_busy[i_rd2_addr] : 1'b0;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - 2R/1W byte-enabled register file with clear sequencer and busy scoreboard
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DEF_DATA_W,
    parameter int NUM_REGS = RF_DEF_NUM_REGS,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NUM_REGS),
    localparam int BE_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     rs1_addr,
    input  logic [AW-1:0]     rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic              busy_set,
    input  logic [AW-1:0]     busy_addr,
    output logic              init_done
);

    localparam logic [AW:0]   NREGS = (AW+1)'(NUM_REGS);
    localparam logic [AW-1:0] LAST  = AW'(NUM_REGS - 1);

    rf_state_e         r_state, w_state_next;
    logic [AW-1:0]     r_clr_cnt;
    logic [DATA_W-1:0] r_mem [NUM_REGS];

    logic              w_run, w_wr_fire, w_set_fire;
    logic [DATA_W-1:0] w_wr_old, w_wr_merged, w_rs1_stored, w_rs2_stored;
    logic              w_rs1_busy_sb, w_rs2_busy_sb;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign w_run      = (r_state == RF_RUN);
    assign w_wr_fire  = w_run && wr_en && addr_ok(wr_addr);
    assign w_set_fire = w_run && busy_set;
    assign w_wr_old   = addr_ok(wr_addr) ? r_mem[wr_addr] : '0;
    assign init_done  = w_run;

    for (genvar g = 0; g < BE_W; g++) begin : g_lane
        assign w_wr_merged[8*g +: 8] = rf_byte_merge(w_wr_old[8*g +: 8], wr_data[8*g +: 8], wr_be[g]);
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= RF_INIT;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RF_INIT: if (r_clr_cnt == LAST) w_state_next = RF_RUN;
            RF_RUN:  w_state_next = RF_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)        r_clr_cnt <= '0;
        else if (!w_run) r_clr_cnt <= r_clr_cnt + AW'(1);
    end

    // Storage has no reset of its own; the INIT sweep zeroes one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!w_run)         r_mem[r_clr_cnt] <= '0;
            else if (w_wr_fire) r_mem[wr_addr]   <= w_wr_merged;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (w_set_fire),
        .i_set_addr (busy_addr),
        .i_clr_en   (w_run && wr_en),
        .i_clr_addr (wr_addr),
        .i_rd1_addr (rs1_addr),
        .i_rd2_addr (rs2_addr),
        .o_rd1_busy (w_rs1_busy_sb),
        .o_rd2_busy (w_rs2_busy_sb)
    );

    assign w_rs1_stored = addr_ok(rs1_addr) ? r_mem[rs1_addr] : '0;
    assign w_rs2_stored = addr_ok(rs2_addr) ? r_mem[rs2_addr] : '0;

    // During INIT reads are forced to zero/busy so decode stalls until the sweep finishes.
    always_comb begin
        rs1_data = w_rs1_stored;
        rs2_data = w_rs2_stored;
        rs1_busy = w_rs1_busy_sb;
        rs2_busy = w_rs2_busy_sb;
        if (!w_run) begin
            rs1_data = '0;
            rs2_data = '0;
            rs1_busy = 1'b1;
            rs2_busy = 1'b1;
        end
`ifdef REGFILE_BYPASS_EN
        else begin
            if (w_wr_fire && (rs1_addr == wr_addr)) begin
                rs1_data = w_wr_merged;
                rs1_busy = w_set_fire && (busy_addr == rs1_addr);
            end
            if (w_wr_fire && (rs2_addr == wr_addr)) begin
                rs2_data = w_wr_merged;
                rs2_busy = w_set_fire && (busy_addr == rs2_addr);
            end
        end
`else
        else begin
            rs1_data = w_rs1_stored;
        end
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed bench for regfile_mp with an expected-value queue and reference model
module tb_regfile_mp;

    localparam int NR = 32;
    localparam int AW = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [AW-1:0] rs1_addr, rs2_addr, wr_addr, busy_addr;
    logic [31:0] rs1_data, rs2_data, wr_data;
    logic        rs1_busy, rs2_busy, wr_en, busy_set, init_done;
    logic [3:0]  wr_be;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .NUM_REGS(NR), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .init_done(init_done)
    );

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;

    logic [31:0] m_mem [NR];
    logic [NR-1:0] m_busy;
    logic        m_run;
    int          m_cnt;

    function automatic logic [31:0] observed(input int kind);
        case (kind)
            0:       return rs1_data;
            1:       return rs2_data;
            2:       return {31'b0, rs1_busy};
            3:       return {31'b0, rs2_busy};
            default: return {31'b0, init_done};
        endcase
    endfunction

    function automatic logic [31:0] m_rd(input logic [AW-1:0] a);
        if (!m_run || a == '0) return 32'h0;
        return m_mem[a];
    endfunction

    function automatic logic [31:0] m_bz(input logic [AW-1:0] a);
        if (!m_run) return 32'h1;
        if (a == '0) return 32'h0;
        return {31'b0, m_busy[a]};
    endfunction

    task automatic expect_val(input string tag, input int kind, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.kind = kind; e.exp = v;
        q.push_back(e);
    endtask

    task automatic check_all();
        exp_t e;
        logic [31:0] o;
        while (q.size() > 0) begin
            e = q.pop_front();
            o = observed(e.kind);
            vectors++;
            assert (o === e.exp) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_run = 1'b0; m_cnt = 0; m_busy = '0;
        end else if (!m_run) begin
            m_mem[m_cnt] = 32'h0;
            if (m_cnt == NR - 1) m_run = 1'b1;
            m_cnt++;
        end else begin
            if (wr_en && wr_addr != '0) begin
                for (int k = 0; k < 4; k++)
                    if (wr_be[k]) m_mem[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
                m_busy[wr_addr] = 1'b0;
            end
            if (busy_set && busy_addr != '0) m_busy[busy_addr] = 1'b1;
        end
    endtask

    task automatic clk_edge();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_be = 4'h0; busy_set = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) m_mem[i] = 'x;
        m_busy = '0; m_run = 1'b0; m_cnt = 0;
        rst = 1'b1; idle();
        wr_addr = '0; wr_data = '0; busy_addr = '0;
        rs1_addr = 5'd4; rs2_addr = 5'd0;

        clk_edge();
        rst = 1'b0; #1;
        expect_val("rst_init_done", 4, 32'h0);
        expect_val("rst_rs1_busy", 2, 32'h1);
        expect_val("rst_rs1_data", 0, 32'h0);
        check_all();
        for (int n = 1; n <= NR; n++) begin
            clk_edge(); #1;
            expect_val("init_done_rise", 4, (n == NR) ? 32'h1 : 32'h0);
            if (n == 10) expect_val("init_rs1_busy", 2, 32'h1);
            check_all();
        end

        for (int a = 0; a < NR; a++) begin
            rs1_addr = AW'(a); rs2_addr = AW'(NR - 1 - a);
            clk_edge(); #1;
            expect_val("sweep_rs1_zero", 0, 32'h0);
            expect_val("sweep_rs2_zero", 1, 32'h0);
            expect_val("sweep_rs1_idle", 2, 32'h0);
            check_all();
        end

        wr(5'd5, 32'hAABBCCDD, 4'b1111);
        clk_edge(); idle(); rs1_addr = 5'd5; #1;
        expect_val("be_full", 0, 32'hAABBCCDD);
        check_all();
        wr(5'd5, 32'h11223344, 4'b0101);
        clk_edge(); idle(); #1;
        expect_val("be_merge", 0, 32'hAA22CC44);
        check_all();

        wr(5'd0, 32'hFFFFFFFF, 4'b1111); busy_set = 1'b1; busy_addr = 5'd0;
        clk_edge(); idle(); rs1_addr = 5'd0; #1;
        expect_val("zero_data", 0, 32'h0);
        expect_val("zero_busy", 2, 32'h0);
        check_all();

        busy_set = 1'b1; busy_addr = 5'd7; rs2_addr = 5'd7;
        clk_edge(); idle(); #1;
        expect_val("busy_set", 3, 32'h1);
        check_all();
        wr(5'd7, 32'h00000077, 4'b1111); busy_set = 1'b1; busy_addr = 5'd7;
        clk_edge(); idle(); #1;
        expect_val("set_wins", 3, 32'h1);
        expect_val("set_wins_data", 1, 32'h00000077);
        check_all();
        wr(5'd7, 32'h00000099, 4'b0000);
        clk_edge(); idle(); #1;
        expect_val("clr_be0", 3, 32'h0);
        expect_val("be0_hold", 1, 32'h00000077);
        check_all();

        rs1_addr = 5'd3;
        wr(5'd3, 32'h12345678, 4'b1111); #1;
`ifdef REGFILE_BYPASS_EN
        expect_val("bypass_data", 0, 32'h12345678);
`else
        expect_val("nobypass_old", 0, 32'h0);
`endif
        expect_val("bypass_busy", 2, 32'h0);
        check_all();
        clk_edge(); idle(); #1;
        expect_val("wr_visible", 0, 32'h12345678);
        check_all();
        wr(5'd3, 32'h0000ABCD, 4'b0011); busy_set = 1'b1; busy_addr = 5'd3; #1;
`ifdef REGFILE_BYPASS_EN
        expect_val("bypass_merge", 0, 32'h1234ABCD);
        expect_val("bypass_set_busy", 2, 32'h1);
`else
        expect_val("nobypass_merge", 0, 32'h12345678);
        expect_val("nobypass_busy", 2, 32'h0);
`endif
        check_all();
        clk_edge(); idle(); #1;
        expect_val("merge_visible", 0, 32'h1234ABCD);
        expect_val("merge_busy", 2, 32'h1);
        check_all();

        for (int i = 0; i < 40; i++) begin
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = AW'($urandom_range(0, 7));
            wr_data   = $urandom;
            wr_be     = 4'($urandom_range(0, 15));
            busy_set  = 1'($urandom_range(0, 1));
            busy_addr = AW'($urandom_range(0, 7));
            clk_edge(); idle();
            rs1_addr = wr_addr; rs2_addr = busy_addr; #1;
            expect_val("rand_rs1_data", 0, m_rd(rs1_addr));
            expect_val("rand_rs2_data", 1, m_rd(rs2_addr));
            expect_val("rand_rs1_busy", 2, m_bz(rs1_addr));
            expect_val("rand_rs2_busy", 3, m_bz(rs2_addr));
            check_all();
        end

        rst = 1'b1;
        clk_edge(); rst = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            clk_edge(); #1;
            expect_val("init1_done_low", 4, 32'h0);
            check_all();
        end
        rst = 1'b1;
        clk_edge(); rst = 1'b0;
        wr(5'd12, 32'hFFFFFFFF, 4'b1111); busy_set = 1'b1; busy_addr = 5'd12;
        for (int n = 1; n <= NR; n++) begin
            clk_edge();
            if (n == 20) idle();
            #1;
            expect_val("restart_init_done", 4, (n == NR) ? 32'h1 : 32'h0);
            check_all();
        end
        rs1_addr = 5'd12; rs2_addr = 5'd5; #1;
        expect_val("init_wr_ignored", 0, 32'h0);
        expect_val("init_set_ignored", 2, 32'h0);
        expect_val("reinit_cleared", 1, 32'h0);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor of the single-issue core register file.
- Two asynchronous read ports and one byte-enabled write port.
- Hardware reset-clear sequencer; the file is zeroed over NUM_REGS cycles rather than preset to index values.
- Per-register busy scoreboard, so the decode stage can stall on pending load/jump writebacks.
- Sits between decode (read/busy side) and writeback (write side) of the DPU.

Parameters:
- DATA_W, 32: register width in bits; must be a multiple of 8.
- NUM_REGS, 32: number of architectural registers; need not be a power of 2.
- ZERO_REG, 1: 1 = register 0 is hardwired to zero and never busy; 0 = register 0 is an ordinary register.
- Derived localparams: AW = $clog2(NUM_REGS); BE_W = DATA_W/8.

Ports:
- clk, input, 1: single clock; all state updates on posedge.
- rst, input, 1: synchronous, active-high reset.
- rs1_addr, input, AW: read port 1 address.
- rs2_addr, input, AW: read port 2 address.
- rs1_data, output, DATA_W: read port 1 data (combinational).
- rs2_data, output, DATA_W: read port 2 data (combinational).
- rs1_busy, output, 1: scoreboard bit for rs1_addr (combinational).
- rs2_busy, output, 1: scoreboard bit for rs2_addr (combinational).
- wr_en, input, 1: writeback write strobe.
- wr_addr, input, AW: write address.
- wr_data, input, DATA_W: write data.
- wr_be, input, BE_W: byte enables; bit k writes byte k.
- busy_set, input, 1: decode issued an instruction whose destination is busy_addr.
- busy_addr, input, AW: register to mark pending.
- init_done, output, 1: high once the clear sequence has completed.

Behaviour:
- Reset:
  - rst high at a posedge puts the FSM in INIT, sets clr_cnt=0, clears all busy bits and drives init_done=0.
  - rst mid-operation, including mid-INIT, restarts the sequence from clr_cnt=0.
- FSM states INIT and RUN:
  - INIT: each cycle writes reg[clr_cnt]=0 and increments clr_cnt. On the cycle clr_cnt==NUM_REGS-1, go to RUN next cycle. init_done goes high exactly NUM_REGS cycles after rst deasserts.
  - RUN: terminal state until the next rst.
- While in INIT:
  - wr_en and busy_set are ignored.
  - rs*_data read 0 and rs*_busy read 1, which forces the decode stage to stall.
- Write (RUN only):
  - When wr_en=1, each byte of reg[wr_addr] with wr_be[k]=1 is updated at the posedge; other bytes are held.
  - The same edge clears busy[wr_addr].
  - wr_be=0 with wr_en=1 still clears the busy bit and leaves the data unchanged.
- Busy set (RUN only): busy_set=1 sets busy[busy_addr] at the posedge.
- Simultaneous busy_set and wr_en to the same address in one cycle: data is written and the busy bit ends at 1 (set wins, because a new producer has been issued).
- Register 0 with ZERO_REG=1: writes and busy_set to register 0 are ignored; rs*_data reads 0 and rs*_busy reads 0.
- Out-of-range address (>= NUM_REGS):
  - Writes and busy_set are ignored.
  - Reads return data 0, busy 0.
- Reads are asynchronous and reflect state after the last posedge (no internal forwarding unless the optional feature is enabled).
- Latency: write to visible read is 1 cycle; busy set/clear to visible busy output is 1 cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when wr_en=1 in RUN and rs1_addr (or rs2_addr) equals wr_addr (valid, and not register 0 when ZERO_REG=1), the read port returns the in-flight merged value. The merged value is wr_data bytes where wr_be=1 and stored bytes elsewhere. The corresponding rs*_busy reads 0 unless busy_set targets the same address in that cycle. This gives same-cycle write-to-read forwarding.
- Undefined: no forwarding; reads see the old value until the next cycle.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_W/NUM_REGS constants;
  - FSM state enum {RF_INIT, RF_RUN};
  - a function computing the byte-merge of old data, new data and wr_be, used by the write path and the bypass path.
- One natural sub-module, regfile_scoreboard: the busy bit vector with set/clear priority, reset clear and the ZERO_REG/out-of-range masking. Storage and the FSM stay in regfile_mp.

Test Plan:
- Reset clear: pulse rst 1 cycle, with NUM_REGS=32.
  - init_done rises on cycle 32 after rst deasserts.
  - During INIT, rs1_busy=1.
  - After init, reading every register returns 0.
- Byte-enable write: in RUN, write reg5 with wr_data=32'hAABBCCDD, wr_be=4'b1111, then wr_data=32'h11223344, wr_be=4'b0101. Next cycle rs1_addr=5 reads 32'hAA22CC44.
- Register 0: write reg0=32'hFFFFFFFF and busy_set reg0 in the same cycle. rs1_data=0 and rs1_busy=0.
- Scoreboard priority:
  - busy_set reg7, then 1 cycle later wr_en reg7 with busy_set reg7 in the same cycle: rs2_busy stays 1.
  - Next cycle, wr_en reg7 alone: rs2_busy=0.
- Reset mid-INIT:
  - Assert rst at INIT cycle 10: init_done stays 0 and a full 32 further cycles are required.
  - A wr_en issued during INIT leaves the target register at 0.
- Bypass (REGFILE_BYPASS_EN defined): write reg3=32'h12345678 while rs1_addr=3. rs1_data=32'h12345678 in the same cycle. With the macro undefined, rs1_data shows the old value until the next cycle.
